// File: rtl/stage_ma.sv
// Memory-access stage: retires ALU results and runs loads/stores over a req/ack data port.
// Build option: define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of forcing alignment.
module stage_ma #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] busc_in,
    input  logic [31:0] rs2_in,
    input  logic [31:0] pc_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    input  logic        is_load,
    input  logic        is_store,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] busc_out,
    output logic [31:0] pc_out,
    output logic [4:0]  rd_out,
    output logic        valid_out,
    output logic        stall,
    output logic        bus_err,
    output logic        misalign
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    lat_lo;
    logic          lat_byte;
    logic          lat_half;
    logic          lat_sign;
    logic          lat_load;
    logic [4:0]    lat_rd;
    logic [31:0]   lat_pc;

    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic [1:0]    eff_lo;
    logic [3:0]    wstrb_nxt;
    logic [31:0]   wdata_nxt;
    logic [31:0]   lane;
    logic [31:0]   load_val;
    logic          timed_out;

    assign stall     = (state == ACCESS);
    assign timed_out = (TIMEOUT_CYC != 0) && (wait_cnt == LAST_CNT);

`ifdef MISALIGN_TRAP_EN
    logic trap_hit;
    assign trap_hit = (is_half && busc_in[0]) || (is_word && (busc_in[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Alignment is forced unconditionally; in the trap build misaligned ops never reach a request.
    always_comb begin
        is_byte   = (funct3_in[1:0] == 2'b00);
        is_half   = (funct3_in[1:0] == 2'b01);
        is_word   = !is_byte && !is_half;
        eff_lo    = busc_in[1:0];
        if (is_half) eff_lo[0] = 1'b0;
        if (is_word) eff_lo = 2'b00;
        wstrb_nxt = 4'b1111;
        wdata_nxt = rs2_in;
        if (is_byte) begin
            wstrb_nxt = 4'b0001 << eff_lo;
            wdata_nxt = {4{rs2_in[7:0]}};
        end else if (is_half) begin
            wstrb_nxt = 4'b0011 << {eff_lo[1], 1'b0};
            wdata_nxt = {2{rs2_in[15:0]}};
        end
        if (is_load) wstrb_nxt = 4'b0000;
    end

    always_comb begin
        lane     = mem_rdata >> {lat_lo, 3'b000};
        load_val = lane;
        if (lat_byte) begin
            load_val = {{24{lat_sign & lane[7]}}, lane[7:0]};
        end else if (lat_half) begin
            load_val = {{16{lat_sign & lane[15]}}, lane[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_lo    <= 2'b00;
            lat_byte  <= 1'b0;
            lat_half  <= 1'b0;
            lat_sign  <= 1'b0;
            lat_load  <= 1'b0;
            lat_rd    <= 5'd0;
            lat_pc    <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
            busc_out  <= 32'd0;
            pc_out    <= 32'd0;
            rd_out    <= 5'd0;
            valid_out <= 1'b0;
            bus_err   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign  <= 1'b0;
`endif
        end else begin
            valid_out <= 1'b0;
            bus_err   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        if (!(is_load || is_store)) begin
                            busc_out  <= busc_in;
                            rd_out    <= rd_in;
                            pc_out    <= pc_in;
                            valid_out <= 1'b1;
                        end
`ifdef MISALIGN_TRAP_EN
                        else if (trap_hit) begin
                            misalign  <= 1'b1;
                            valid_out <= 1'b1;
                            rd_out    <= 5'd0;
                            busc_out  <= busc_in;
                            pc_out    <= pc_in;
                        end
`endif
                        else begin
                            lat_lo    <= eff_lo;
                            lat_byte  <= is_byte;
                            lat_half  <= is_half;
                            lat_sign  <= !funct3_in[2];
                            lat_load  <= is_load;
                            lat_rd    <= rd_in;
                            lat_pc    <= pc_in;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {busc_in[31:2], 2'b00};
                            mem_wstrb <= wstrb_nxt;
                            mem_wdata <= wdata_nxt;
                            wait_cnt  <= '0;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Ack has priority over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        valid_out <= 1'b1;
                        pc_out    <= lat_pc;
                        busc_out  <= lat_load ? load_val : 32'd0;
                        rd_out    <= lat_load ? lat_rd : 5'd0;
                        state     <= IDLE;
                    end else if (timed_out) begin
                        mem_req   <= 1'b0;
                        bus_err   <= 1'b1;
                        valid_out <= 1'b1;
                        rd_out    <= 5'd0;
                        pc_out    <= lat_pc;
                        state     <= IDLE;
                    end else begin
                        wait_cnt  <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_ma.sv
// Directed self-checking bench for stage_ma: ALU pass-through, loads/stores, timeout, reset, alignment.
module tb_stage_ma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] busc_in = '0;
    logic [31:0] rs2_in = '0;
    logic [31:0] pc_in = '0;
    logic [4:0]  rd_in = '0;
    logic [2:0]  funct3_in = '0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] busc_out;
    logic [31:0] pc_out;
    logic [4:0]  rd_out;
    logic        valid_out;
    logic        stall;
    logic        bus_err;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    stage_ma #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .busc_in(busc_in), .rs2_in(rs2_in),
        .pc_in(pc_in), .rd_in(rd_in), .funct3_in(funct3_in), .is_load(is_load), .is_store(is_store),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busc_out(busc_out),
        .pc_out(pc_out), .rd_out(rd_out), .valid_out(valid_out), .stall(stall),
        .bus_err(bus_err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d, input logic [31:0] p,
                                 input logic [4:0] r);
        valid_in  = v;
        is_load   = ld;
        is_store  = st;
        funct3_in = f3;
        busc_in   = a;
        rs2_in    = d;
        pc_in     = p;
        rd_in     = r;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runAlu(input string tag, input logic [31:0] val, input logic [4:0] r);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, val, 32'h0, 32'h2000 + val, r);
        checkOutput({tag, " stall"}, stall, 0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        checkOutput({tag, " valid"}, valid_out, 1);
        checkOutput({tag, " busc"}, busc_out, val);
        checkOutput({tag, " rd"}, rd_out, r);
        checkOutput({tag, " pc"}, pc_out, 32'h2000 + val);
        checkOutput({tag, " stall after"}, stall, 0);
    endtask

    task automatic runMem(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                          input int wait_cyc, input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_busc, input logic [4:0] exp_rd);
        applyStimulus(1'b1, ld, st, f3, a, d, 32'h1000 + a, r);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        checkOutput({tag, " req"}, mem_req, 1);
        checkOutput({tag, " we"}, mem_we, st);
        checkOutput({tag, " addr"}, mem_addr, exp_addr);
        checkOutput({tag, " wstrb"}, mem_wstrb, exp_strb);
        checkOutput({tag, " stall"}, stall, 1);
        if (st) checkOutput({tag, " wdata"}, mem_wdata, exp_wdata);
        for (int i = 0; i < wait_cyc; i++) begin
            stepCycle();
            checkOutput({tag, " stall wait"}, stall, 1);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        stepCycle();
        mem_ack   = 1'b0;
        checkOutput({tag, " valid"}, valid_out, 1);
        checkOutput({tag, " busc"}, busc_out, exp_busc);
        checkOutput({tag, " rd"}, rd_out, exp_rd);
        checkOutput({tag, " pc"}, pc_out, 32'h1000 + a);
        checkOutput({tag, " req drop"}, mem_req, 0);
        checkOutput({tag, " stall drop"}, stall, 0);
        checkOutput({tag, " bus_err"}, bus_err, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        checkOutput("reset valid", valid_out, 0);
        checkOutput("reset req", mem_req, 0);
        checkOutput("reset stall", stall, 0);
        checkOutput("reset busc", busc_out, 0);
        checkOutput("reset rd", rd_out, 0);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("idle valid", valid_out, 0);

        runAlu("alu", 32'h0000_1234, 5'd5);
        runAlu("alu x0", 32'hFFFF_0001, 5'd0);
        stepCycle();
        checkOutput("valid pulse", valid_out, 0);

        // tag, ld, st, f3, addr, rs2, rd, wait, rdata, exp addr, strb, wdata, busc, rd
        runMem("lb", 1, 0, 3'b000, 32'h103, 32'h0, 5'd7, 0, 32'h80FF_0000,
               32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80, 5'd7);
        runMem("lbu", 1, 0, 3'b100, 32'h101, 32'h0, 5'd8, 1, 32'h12F0_3456,
               32'h100, 4'b0000, 32'h0, 32'h0000_0034, 5'd8);
        runMem("lh", 1, 0, 3'b001, 32'h106, 32'h0, 5'd9, 0, 32'h8001_7FFF,
               32'h104, 4'b0000, 32'h0, 32'hFFFF_8001, 5'd9);
        runMem("lhu", 1, 0, 3'b101, 32'h106, 32'h0, 5'd10, 0, 32'h8001_7FFF,
               32'h104, 4'b0000, 32'h0, 32'h0000_8001, 5'd10);
        runMem("lw", 1, 0, 3'b010, 32'h108, 32'h0, 5'd11, 0, 32'hCAFE_F00D,
               32'h108, 4'b0000, 32'h0, 32'hCAFE_F00D, 5'd11);
        runMem("sh", 0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd12, 2, 32'h0,
               32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0, 5'd0);
        runMem("sb", 0, 1, 3'b000, 32'h005, 32'h1234_56A5, 5'd13, 0, 32'h0,
               32'h004, 4'b0010, 32'hA5A5_A5A5, 32'h0, 5'd0);
        runMem("sw", 0, 1, 3'b010, 32'h010, 32'hCAFE_BABE, 5'd14, 0, 32'h0,
               32'h010, 4'b1111, 32'hCAFE_BABE, 32'h0, 5'd0);

        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h1300, 5'd9);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            stepCycle();
        end
        checkOutput("timeout cycles", n, 16);
        checkOutput("timeout bus_err", bus_err, 1);
        checkOutput("timeout valid", valid_out, 1);
        checkOutput("timeout rd", rd_out, 0);
        checkOutput("timeout pc", pc_out, 32'h1300);
        stepCycle();
        checkOutput("bus_err pulse", bus_err, 0);
        checkOutput("timeout idle", stall, 0);

        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h1400, 5'd3);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        checkOutput("pre-reset req", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset req", mem_req, 0);
        checkOutput("async reset stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_5555;
        stepCycle();
        mem_ack = 1'b0;
        checkOutput("late ack valid", valid_out, 0);
        checkOutput("late ack req", mem_req, 0);
        runAlu("alu post-reset", 32'h0000_00AB, 5'd2);

`ifdef MISALIGN_TRAP_EN
        applyStimulus(1'b1, 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h1101, 5'd6);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        checkOutput("trap misalign", misalign, 1);
        checkOutput("trap req", mem_req, 0);
        checkOutput("trap valid", valid_out, 1);
        checkOutput("trap rd", rd_out, 0);
        checkOutput("trap busc", busc_out, 32'h101);
        checkOutput("trap stall", stall, 0);
        stepCycle();
        checkOutput("misalign pulse", misalign, 0);
`else
        runMem("lw unaligned", 1, 0, 3'b010, 32'h101, 32'h0, 5'd6, 0, 32'hDEAD_BEEF,
               32'h100, 4'b0000, 32'h0, 32'hDEAD_BEEF, 5'd6);
        checkOutput("misalign tied", misalign, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
